// File: rtl/seq_det_param.sv
// Parametrised W-bit, LEN-symbol pattern detector with Mealy (z) and registered (zq) match outputs.
// Optional saturating match counter enabled by defining SEQ_DET_PARAM_CNT_EN.
module seq_det_param #(
  parameter int W     = 2,
  parameter int LEN   = 3,
  parameter logic [W*LEN-1:0] PATTERN = 6'b01_11_10,
  parameter int CNT_W = 8
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     x,
  input  logic             ovl,
  output logic             z,
  output logic             zq,
  output logic [CNT_W-1:0] cnt
);

  localparam int HW = W*(LEN-1);
  localparam int FW = $clog2(LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(LEN-1);

  function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
    return (f == FILL_MAX) ? f : f + FW'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [HW-1:0]   hist, hist_nxt;
  logic [FW-1:0]   fill, fill_nxt;
  logic [HW+W-1:0] window;
  logic            z_p1;

  // Stage 0: match decision and next history/fill, combinational from state and x
  always_comb begin
    window   = {hist, x};
    z        = en && (fill == FILL_MAX) && (window == PATTERN);
    hist_nxt = hist;
    fill_nxt = fill;
    if (en) begin
      hist_nxt = window[HW-1:0];
      if (z && !ovl)
        fill_nxt = '0;
      else
        fill_nxt = fill_sat_inc(fill);
    end
  end

  // Stage 1: state and registered match
  always_ff @(posedge cp) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      z_p1 <= 1'b0;
    end else begin
      hist <= hist_nxt;
      fill <= fill_nxt;
      z_p1 <= z;
    end
  end

  assign zq = z_p1;

`ifdef SEQ_DET_PARAM_CNT_EN
  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge cp) begin
    if (rst)
      cnt_p1 <= '0;
    else if (z)
      cnt_p1 <= cnt_sat_inc(cnt_p1);
  end

  assign cnt = cnt_p1;
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: three parameterisations share stimulus; each scenario
// checks z per symbol, zq one symbol later, and the counter against a small reference model.
module tb_seq_det_param;

`ifdef SEQ_DET_PARAM_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       cp = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] x = 2'b00;
  logic       ovl = 1'b1;

  logic [2:0] z_v, zq_v;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [7:0] cnt_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cp = ~cp;

  seq_det_param #(.W(2), .LEN(3), .PATTERN(6'b01_11_10), .CNT_W(8)) u_def (
    .cp(cp), .rst(rst), .en(en), .x(x), .ovl(ovl), .z(z_v[0]), .zq(zq_v[0]), .cnt(cnt0));

  seq_det_param #(.W(2), .LEN(3), .PATTERN(6'b01_01_01), .CNT_W(8)) u_rep (
    .cp(cp), .rst(rst), .en(en), .x(x), .ovl(ovl), .z(z_v[1]), .zq(zq_v[1]), .cnt(cnt1));

  seq_det_param #(.W(2), .LEN(3), .PATTERN(6'b01_01_01), .CNT_W(2)) u_sat (
    .cp(cp), .rst(rst), .en(en), .x(x), .ovl(ovl), .z(z_v[2]), .zq(zq_v[2]), .cnt(cnt2));

  assign cnt_v[0] = cnt0;
  assign cnt_v[1] = cnt1;
  assign cnt_v[2] = {6'b0, cnt2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [1:0] s);
    @(negedge cp);
    rst = r;
    en  = e;
    x   = s;
    #1;
  endtask

  // Vectors are listed oldest-first in the MSBs; bit i of each mask belongs to step i.
  task automatic run(input string name, input int d, input logic o, input int n,
                     input logic [31:0] syms, input logic [15:0] ez,
                     input logic [15:0] em, input logic [15:0] rm);
    logic       pz;
    int         mcnt;
    int         cmax;
    logic [1:0] s;
    logic       zi, ei, ri;
    cmax = (d == 2) ? 3 : 255;
    ovl  = o;
    apply(1'b1, 1'b0, 2'b00);
    pz   = 1'b0;
    mcnt = 0;
    for (int i = 0; i < n; i++) begin
      s  = syms[2*(n-1-i) +: 2];
      zi = ez[n-1-i];
      ei = em[n-1-i];
      ri = rm[n-1-i];
      apply(ri, ei, s);
      chk($sformatf("%s.z[%0d]", name, i), {31'b0, z_v[d]}, {31'b0, zi});
      chk($sformatf("%s.zq[%0d]", name, i), {31'b0, zq_v[d]}, {31'b0, pz});
      chk($sformatf("%s.cnt[%0d]", name, i), {24'b0, cnt_v[d]}, CNT_ON ? mcnt : 0);
      if (ri) begin
        pz   = 1'b0;
        mcnt = 0;
      end else begin
        pz = zi;
        if (zi && mcnt < cmax) mcnt++;
      end
    end
    apply(1'b0, 1'b0, 2'b00);
    chk($sformatf("%s.zq_end", name), {31'b0, zq_v[d]}, {31'b0, pz});
    chk($sformatf("%s.cnt_end", name), {24'b0, cnt_v[d]}, CNT_ON ? mcnt : 0);
  endtask

  initial begin
    // Reference sequence 00,01,10,11,01,11,10,00: only the 7th symbol completes 01,11,10
    run("s1_basic", 0, 1'b1, 8, 32'(16'b00_01_10_11_01_11_10_00),
        16'(8'b0000_0010), 16'(8'hFF), 16'(8'h00));
    // Repeating 01 with overlap: every symbol from the 3rd on matches
    run("s2_ovl", 1, 1'b1, 5, 32'(10'b01_01_01_01_01),
        16'(5'b00111), 16'(5'b11111), 16'(5'b00000));
    // Without overlap the fill restarts after a match, so the next hit is on symbol 6
    run("s3_novl", 1, 1'b0, 6, 32'(12'b01_01_01_01_01_01),
        16'(6'b001001), 16'(6'b111111), 16'(6'b000000));
    // en=0 gap of four cycles holding x=10: no match until en returns
    run("s4_gap", 0, 1'b1, 7, 32'(14'b01_11_10_10_10_10_10),
        16'(7'b0000001), 16'(7'b1100001), 16'(7'b0000000));
    // Reset mid-pattern discards progress; a fresh full pattern matches again
    run("s5_rst", 0, 1'b1, 7, 32'(14'b01_11_00_10_01_11_10),
        16'(7'b0000001), 16'(7'b1101111), 16'(7'b0010000));
    // Reset coincident with the completing symbol: z high, but zq and cnt cleared
    run("s5_rst_hit", 0, 1'b1, 3, 32'(6'b01_11_10),
        16'(3'b001), 16'(3'b111), 16'(3'b001));
    // Two-bit counter saturates at 3 across six matches
    run("s6_sat", 2, 1'b1, 8, 32'(16'b01_01_01_01_01_01_01_01),
        16'(8'b0011_1111), 16'(8'hFF), 16'(8'h00));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised synchronous sequence detector. It generalises the two-input (x1,x2) single-state-bit textbook FSM into an N-symbol pattern matcher with W-bit input symbols. The block holds its own state internally; no external next-state feedback loop is needed. It provides a Mealy match output, a registered (Moore-style) copy, selectable overlapping or non-overlapping detection, and an optional match counter. It sits in the lab sequential-circuit examples, driven by the board switches and displayed on the board LEDs.

Parameters:
W, 2, input symbol width (>=1)
LEN, 3, pattern length in symbols (>=2)
PATTERN, 6'b01_11_10, W*LEN bits; first (oldest) symbol in the MSBs, last symbol in the LSBs
CNT_W, 8, match counter width (>=1)

Ports:
cp  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high; priority over all other inputs
en  input  1  symbol-valid strobe; x is sampled only when en=1
x  input  W  current input symbol
ovl  input  1  1 = overlapping detection, 0 = non-overlapping
z  output  1  Mealy match, combinational from the current state and x
zq  output  1  z registered; one cycle of latency
cnt  output  CNT_W  saturating match count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, cp. Reset is synchronous and active-high on rst.
- State:
  - hist: W*(LEN-1) bits, the last LEN-1 accepted symbols, newest in the LSBs.
  - fill: 0..LEN-1, the number of valid symbols in hist, saturating at LEN-1.
- Reset (rst=1 at the edge): hist=0, fill=0, zq=0, cnt=0. z is 0 while fill<LEN-1. A reset mid-pattern discards all partial progress.
- Match term: z = en & (fill==LEN-1) & ({hist, x} == PATTERN). z is purely combinational, so it is valid in the same cycle the last symbol is presented.
- On a rising edge with en=1 and rst=0:
  - hist <= {hist[W*(LEN-2)-1:0], x}. For LEN=2, hist <= x.
  - If z=1 and ovl=0: fill <= 0. The next match needs LEN fresh symbols.
  - Otherwise: fill <= min(fill+1, LEN-1).
- With en=0: hist and fill hold; z=0.
- zq <= z on every edge. zq is 0 in the cycle after reset.
- ovl may change at any time. It takes effect at the next match decision and does not alter the current fill.
- Back-to-back matches:
  - ovl=1: z may be high on consecutive accepted symbols, e.g. pattern 01,01,01 fed with 01s.
  - ovl=0: consecutive z pulses are at least LEN accepted symbols apart.
- Simultaneous rst and en with a match present: reset wins. zq, cnt and fill go to 0; nothing is counted.

Optional Feature:
- Macro: SEQ_DET_PARAM_CNT_EN
- Defined:
  - cnt increments by 1 on each edge where z=1 and rst=0.
  - cnt saturates at 2^CNT_W-1 and never wraps.
  - cnt resets to 0.
- Undefined: no counter register is built, and cnt is tied to 0.

Test Plan:
1. Defaults (W=2, LEN=3, PATTERN=01_11_10), ovl=1, en=1, one symbol per cycle. Drive 00,01,10,11,01,11,10,00. Required: z=1 only while the 7th symbol (10) is present; zq=1 in the following cycle only; cnt=1 with the macro defined.
2. PATTERN=01_01_01, ovl=1. Drive five symbols of 01. Required: z=1 on symbols 3, 4 and 5; cnt=3.
3. Same as scenario 2 with ovl=0. Required: z=1 on symbol 3 only; cnt=1. A 6th symbol of 01 gives z=1 again.
4. Defaults. Drive 01,11, then hold en=0 for 4 cycles with x=10, then en=1 with x=10. Required: z=0 throughout the en=0 gap; z=1 when en returns.
5. Defaults. Drive 01,11, then assert rst for one cycle, then drive 10. Required: z=0; fill=0 after reset; cnt unchanged at 0. Repeat with rst asserted in the same cycle as the matching 10 symbol: z=1 combinationally, but zq=0 and cnt=0 after the edge.
6. CNT_W=2, PATTERN=01_01_01, ovl=1, macro defined. Drive 8 symbols of 01 (6 matches). Required: cnt goes 1, 2, 3, then holds at 3. With the macro undefined, cnt=0 throughout.
